// File: rtl/lzc_norm_pipe.sv
// Two-stage normalizer: stage 1 captures the mantissa, exponent and its leading-zero
// count; stage 2 left-shifts by min(lzc, exp) and adjusts the exponent.
module lzc_norm_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3,
  parameter int EXP_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [EXP_W-1:0] in_exp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [EXP_W-1:0] out_exp,
  output logic [CNT_W-1:0] out_shamt,
  output logic             out_zero,
  output logic             out_uflow
);

  localparam int MW = (CNT_W > EXP_W) ? CNT_W : EXP_W;

  // Valid/ready: a beat moves when valid && ready; a stage may load when it is
  // empty or its downstream is moving, so in_ready depends combinationally on out_ready only.

  // Dichotomy search: halve the window each step; an all-zero word yields all ones (WIDTH-1).
  function automatic logic [CNT_W-1:0] lzc_f(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] x;
    logic [CNT_W-1:0] cnt;
    x   = v;
    cnt = '0;
    for (int i = CNT_W - 1; i >= 0; i--) begin
      if ((x & ~({WIDTH{1'b1}} >> (1 << i))) == '0) begin
        cnt[i] = 1'b1;
        x      = x << (1 << i);
      end
    end
    return cnt;
  endfunction

  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_data_q;
  logic [EXP_W-1:0] s1_exp_q;
  logic [CNT_W-1:0] s1_lzc_q;

  logic             s2_valid_q;
  logic [WIDTH-1:0] s2_data_q, s2_data_d;
  logic [EXP_W-1:0] s2_exp_q, s2_exp_d;
  logic [CNT_W-1:0] s2_shamt_q, s2_shamt_d;
  logic             s2_zero_q, s2_zero_d;
  logic             s2_uflow_q, s2_uflow_d;

  logic             s1_en, s2_en, accept;
  logic             limited;
  logic [CNT_W-1:0] shamt;

  assign s2_en    = !s2_valid_q || out_ready;
  assign s1_en    = !s1_valid_q || s2_en;
  assign in_ready = s1_en;
  assign accept   = in_valid && s1_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_exp_q   <= '0;
      s1_lzc_q   <= '0;
    end else begin
      if (s1_en) s1_valid_q <= in_valid;
      if (accept) begin
        s1_data_q <= in_data;
        s1_exp_q  <= in_exp;
        s1_lzc_q  <= lzc_f(in_data);
      end
    end
  end

  // The shift is capped by the exponent so it never goes below zero; zero input is exempt.
  always_comb begin
    limited    = MW'(s1_lzc_q) > MW'(s1_exp_q);
    shamt      = limited ? CNT_W'(s1_exp_q) : s1_lzc_q;
    s2_data_d  = s1_data_q << shamt;
    s2_exp_d   = s1_exp_q - EXP_W'(shamt);
    s2_shamt_d = shamt;
    s2_zero_d  = 1'b0;
    s2_uflow_d = limited;
    if (s1_data_q == '0) begin
      s2_data_d  = '0;
      s2_exp_d   = '0;
      s2_shamt_d = CNT_W'(WIDTH - 1);
      s2_zero_d  = 1'b1;
      s2_uflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_exp_q   <= '0;
      s2_shamt_q <= '0;
      s2_zero_q  <= 1'b0;
      s2_uflow_q <= 1'b0;
    end else if (s2_en) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_data_q  <= s2_data_d;
        s2_exp_q   <= s2_exp_d;
        s2_shamt_q <= s2_shamt_d;
        s2_zero_q  <= s2_zero_d;
        s2_uflow_q <= s2_uflow_d;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;
  assign out_exp   = s2_exp_q;
  assign out_shamt = s2_shamt_q;
  assign out_zero  = s2_zero_q;
  assign out_uflow = s2_uflow_q;

endmodule
